// File: rtl/issue_queue.sv
// issue_queue: age-ordered collapsing issue queue with tag wakeup and oldest-ready select.
// Rev 1.0
`default_nettype none

package issue_queue_pkg;
   localparam int PRF_W  = 6;
   localparam int DISP_W = 4;

   typedef struct packed {
      logic             valid;
      logic [1:0]       iq_code;
      logic [7:0]       rob_idx;
      logic [PRF_W-1:0] rd;
      logic [PRF_W-1:0] rs1;
      logic             rs1_valid;
      logic [PRF_W-1:0] rs2;
      logic             rs2_valid;
   } micro_op_t;
endpackage

module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int IQ_SIZE        = 16,
   parameter int PRF_IDX_WIDTH  = PRF_W,
   parameter int WAKE_WIDTH     = 3,
   parameter int DISPATCH_WIDTH = DISP_W
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic                                      flush,
   input  micro_op_t [DISPATCH_WIDTH-1:0]            uop_in,
   input  logic [DISPATCH_WIDTH-1:0]                 rs1_ready_in,
   input  logic [DISPATCH_WIDTH-1:0]                 rs2_ready_in,
   input  logic [WAKE_WIDTH-1:0]                     wake_valid,
   input  logic [WAKE_WIDTH-1:0][PRF_IDX_WIDTH-1:0]  wake_tag,
   input  logic                                      ex_ready,
   output logic                                      iq_full,
   output micro_op_t                                 uop_out
);

   localparam int CNT_W = $clog2(IQ_SIZE + 1);

   function automatic logic f_hit(
      input logic [PRF_IDX_WIDTH-1:0]                 tag,
      input logic [WAKE_WIDTH-1:0]                    v,
      input logic [WAKE_WIDTH-1:0][PRF_IDX_WIDTH-1:0] t
   );
      f_hit = 1'b0;
      for (int w = 0; w < WAKE_WIDTH; w++) begin
         if (v[w] && (t[w] == tag)) f_hit = 1'b1;
      end
   endfunction

   micro_op_t          r_ent [IQ_SIZE];
   logic [IQ_SIZE-1:0] r_rdy1, r_rdy2;
   logic [CNT_W-1:0]   r_count;
   logic               r_full;
   micro_op_t          r_out;

   micro_op_t          w_ent [IQ_SIZE];
   logic [IQ_SIZE-1:0] w_rdy1, w_rdy2, w_up1, w_up2;
   logic               w_take, w_found, w_remove;
   logic [CNT_W-1:0]   w_win, w_base, w_off, w_cnt_n;
   micro_op_t          w_win_uop;

   always_comb begin
      w_take    = !r_out.valid || ex_ready;
      w_found   = 1'b0;
      w_win     = '0;
      w_win_uop = '0;
      w_up1     = '0;
      w_up2     = '0;
      // Descending scan so the lowest eligible index is the final winner.
      for (int i = IQ_SIZE - 1; i >= 0; i--) begin
         w_up1[i] = r_ent[i].valid & (r_rdy1[i] | f_hit(r_ent[i].rs1, wake_valid, wake_tag));
         w_up2[i] = r_ent[i].valid & (r_rdy2[i] | f_hit(r_ent[i].rs2, wake_valid, wake_tag));
         if (r_ent[i].valid && r_rdy1[i] && r_rdy2[i]) begin
            w_found   = 1'b1;
            w_win     = CNT_W'(i);
            w_win_uop = r_ent[i];
         end
      end
      w_remove = w_take & w_found;
      w_base   = r_count - CNT_W'(w_remove);

      for (int i = 0; i < IQ_SIZE; i++) begin
         w_ent[i]  = '0;
         w_rdy1[i] = 1'b0;
         w_rdy2[i] = 1'b0;
         if (w_remove && (CNT_W'(i) >= w_win)) begin
            if (i < IQ_SIZE - 1) begin
               w_ent[i]  = r_ent[(i + 1) % IQ_SIZE];
               w_rdy1[i] = w_up1[(i + 1) % IQ_SIZE];
               w_rdy2[i] = w_up2[(i + 1) % IQ_SIZE];
            end
         end else begin
            w_ent[i]  = r_ent[i];
            w_rdy1[i] = w_up1[i];
            w_rdy2[i] = w_up2[i];
         end
      end

      // Append accepted lanes behind the surviving entries, in lane order.
      w_off = '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
         if (uop_in[k].valid && !r_full) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
               if (CNT_W'(i) == (w_base + w_off)) begin
                  w_ent[i]  = uop_in[k];
                  w_rdy1[i] = rs1_ready_in[k] | !uop_in[k].rs1_valid
                              | f_hit(uop_in[k].rs1, wake_valid, wake_tag);
                  w_rdy2[i] = rs2_ready_in[k] | !uop_in[k].rs2_valid
                              | f_hit(uop_in[k].rs2, wake_valid, wake_tag);
               end
            end
            w_off = w_off + CNT_W'(1);
         end
      end
      w_cnt_n = w_base + w_off;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < IQ_SIZE; i++) r_ent[i] <= '0;
         r_rdy1  <= '0;
         r_rdy2  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_out   <= '0;
      end else if (flush) begin
         for (int i = 0; i < IQ_SIZE; i++) r_ent[i] <= '0;
         r_rdy1  <= '0;
         r_rdy2  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_out   <= '0;
      end else begin
         for (int i = 0; i < IQ_SIZE; i++) r_ent[i] <= w_ent[i];
         r_rdy1  <= w_rdy1;
         r_rdy2  <= w_rdy2;
         r_count <= w_cnt_n;
         r_full  <= (w_cnt_n > CNT_W'(IQ_SIZE - DISPATCH_WIDTH));
         if (w_take) r_out <= w_found ? w_win_uop : '0;
      end
   end

   assign iq_full = r_full;
   assign uop_out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed self-checking bench for issue_queue.
// Rev 1.0
`default_nettype none

module tb_issue_queue;
   import issue_queue_pkg::*;

   localparam int DW = 4;
   localparam int WW = 3;
   localparam int PW = 6;

   logic                    clock = 1'b0;
   logic                    reset, flush, ex_ready, iq_full;
   micro_op_t [DW-1:0]      uop_in;
   logic [DW-1:0]           rs1_ready_in, rs2_ready_in;
   logic [WW-1:0]           wake_valid;
   logic [WW-1:0][PW-1:0]   wake_tag;
   micro_op_t               uop_out;

   int n_chk  = 0;
   int n_fail = 0;

   issue_queue dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .uop_in       (uop_in),
      .rs1_ready_in (rs1_ready_in),
      .rs2_ready_in (rs2_ready_in),
      .wake_valid   (wake_valid),
      .wake_tag     (wake_tag),
      .ex_ready     (ex_ready),
      .iq_full      (iq_full),
      .uop_out      (uop_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic micro_op_t mk(input logic [7:0] id, input logic [5:0] s1, input logic v1,
                                    input logic [5:0] s2, input logic v2);
      micro_op_t u;
      u           = '0;
      u.valid     = 1'b1;
      u.iq_code   = 2'd1;
      u.rob_idx   = id;
      u.rd        = id[5:0];
      u.rs1       = s1;
      u.rs1_valid = v1;
      u.rs2       = s2;
      u.rs2_valid = v2;
      return u;
   endfunction

   task automatic lane(input int k, input micro_op_t u, input logic r1, input logic r2);
      uop_in[k]       = u;
      rs1_ready_in[k] = r1;
      rs2_ready_in[k] = r2;
   endtask

   task automatic clr_in();
      uop_in       = '0;
      rs1_ready_in = '0;
      rs2_ready_in = '0;
   endtask

   // One clock edge; inputs change and outputs are sampled on the falling edge.
   task automatic step();
      logic any_v;
      any_v = 1'b0;
      for (int k = 0; k < DW; k++) any_v |= uop_in[k].valid;
      if (any_v && !flush) chk("disp_while_full", iq_full, 1'b0);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wake(input int p, input logic [5:0] t);
      wake_valid[p] = 1'b1;
      wake_tag[p]   = t;
   endtask

   logic [7:0] order [15];

   initial begin
      reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
      wake_valid = '0; wake_tag = '0;
      clr_in();
      repeat (2) @(negedge clock);
      chk("rst_uop_out", uop_out, 0);
      chk("rst_iq_full", iq_full, 0);
      chk("rst_count", dut.r_count, 0);
      reset = 1'b0;

      // Four ready uops issue oldest-first, one per cycle.
      for (int k = 0; k < 4; k++) lane(k, mk(8'hA0 + 8'(k), 6'd0, 1'b0, 6'd0, 1'b0), 1'b0, 1'b0);
      step(); clr_in();
      chk("t1_count_after_disp", dut.r_count, 4);
      chk("t1_no_bypass", uop_out.valid, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_issue_id", uop_out.rob_idx, 8'hA0 + 8'(i));
         chk("t1_count", dut.r_count, 3 - i);
      end
      step();
      chk("t1_drain_idle", uop_out.valid, 0);

      // Younger ready uop bypasses an older waiting one; a tag without valid must not wake.
      wake_tag[0] = 6'd5;
      lane(0, mk(8'hB0, 6'd5, 1'b1, 6'd0, 1'b0), 1'b0, 1'b0);
      step(); clr_in();
      lane(0, mk(8'hB1, 6'd6, 1'b1, 6'd0, 1'b0), 1'b1, 1'b0);
      step(); clr_in();
      chk("t2_nothing_ready", uop_out.valid, 0);
      chk("t2_count", dut.r_count, 2);
      step();
      chk("t2_young_first", uop_out.rob_idx, 8'hB1);
      wake(1, 6'd5);
      step(); wake_valid = '0;
      chk("t2_wake_edge_idle", uop_out.valid, 0);
      step();
      chk("t2_woken_issue", uop_out.rob_idx, 8'hB0);
      chk("t2_count_empty", dut.r_count, 0);

      // Dual-source wakeup and same-cycle wakeup of an incoming uop.
      lane(0, mk(8'hC0, 6'd9, 1'b1, 6'd9, 1'b1), 1'b0, 1'b0);
      step(); clr_in();
      wake(2, 6'd9); wake(0, 6'd7);
      lane(0, mk(8'hC1, 6'd7, 1'b1, 6'd0, 1'b0), 1'b0, 1'b0);
      step(); clr_in(); wake_valid = '0;
      chk("t2b_idle", uop_out.valid, 0);
      step();
      chk("t2b_both_srcs", uop_out.rob_idx, 8'hC0);
      step();
      chk("t2b_incoming_wake", uop_out.rob_idx, 8'hC1);
      chk("t2b_count", dut.r_count, 0);

      // Fill to 13 entries waiting on tag 20 (0x13 on 22, 0x1C on 21).
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < 4; k++) begin
            logic [7:0] id;
            id = 8'h10 + 8'(4 * g + k);
            lane(k, mk(id, (id == 8'h13) ? 6'd22 : 6'd20, 1'b1, 6'd0, 1'b0), 1'b0, 1'b0);
         end
         step(); clr_in();
         chk("t3_fill_count", dut.r_count, 4 * (g + 1));
         chk("t3_fill_not_full", iq_full, 0);
      end
      lane(0, mk(8'h1C, 6'd21, 1'b1, 6'd0, 1'b0), 1'b0, 1'b0);
      step(); clr_in();
      chk("t3_count13", dut.r_count, 13);
      chk("t3_full", iq_full, 1);
      wake(0, 6'd21);
      step(); wake_valid = '0;
      chk("t3_full_hold", iq_full, 1);
      step();
      chk("t3_issue_1c", uop_out.rob_idx, 8'h1C);
      chk("t3_count12", dut.r_count, 12);
      chk("t3_not_full", iq_full, 0);

      // Issue from the middle while dispatching a full group at count 12.
      wake(0, 6'd22);
      step(); wake_valid = '0;
      chk("t5_idle", uop_out.valid, 0);
      for (int k = 0; k < 4; k++) lane(k, mk(8'h20 + 8'(k), 6'd20, 1'b1, 6'd0, 1'b0), 1'b0, 1'b0);
      step(); clr_in();
      chk("t5_issue_13", uop_out.rob_idx, 8'h13);
      chk("t5_count15", dut.r_count, 15);
      chk("t5_full", iq_full, 1);

      // Back-pressure for 5 cycles while wakeup of tag 20 still lands.
      ex_ready = 1'b0;
      wake(0, 6'd20);
      for (int i = 0; i < 5; i++) begin
         step(); wake_valid = '0;
         chk("t4_stall_id", uop_out.rob_idx, 8'h13);
         chk("t4_stall_valid", uop_out.valid, 1);
         chk("t4_stall_count", dut.r_count, 15);
      end
      ex_ready = 1'b1;
      order = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
                8'h19, 8'h1A, 8'h1B, 8'h20, 8'h21, 8'h22, 8'h23};
      for (int i = 0; i < 15; i++) begin
         step();
         chk("t4_order_id", uop_out.rob_idx, order[i]);
         chk("t4_order_count", dut.r_count, 14 - i);
         chk("t4_order_full", iq_full, (14 - i) > 12);
      end
      step();
      chk("t4_empty", uop_out.valid, 0);

      // Flush with 8 entries and a held uop_out; same-cycle dispatch dropped.
      for (int k = 0; k < 4; k++) lane(k, mk(8'h30 + 8'(k), 6'd0, 1'b0, 6'd0, 1'b0), 1'b0, 1'b0);
      step();
      for (int k = 0; k < 4; k++) lane(k, mk(8'h34 + 8'(k), 6'd0, 1'b0, 6'd0, 1'b0), 1'b0, 1'b0);
      step(); clr_in();
      chk("t6_issue_30", uop_out.rob_idx, 8'h30);
      ex_ready = 1'b0;
      lane(0, mk(8'h38, 6'd0, 1'b0, 6'd0, 1'b0), 1'b0, 1'b0);
      step(); clr_in();
      chk("t6_count8", dut.r_count, 8);
      chk("t6_out_held", uop_out.rob_idx, 8'h30);
      flush = 1'b1; ex_ready = 1'b1;
      for (int k = 0; k < 4; k++) lane(k, mk(8'h39 + 8'(k), 6'd0, 1'b0, 6'd0, 1'b0), 1'b0, 1'b0);
      step(); flush = 1'b0; clr_in();
      chk("t6_flush_count", dut.r_count, 0);
      chk("t6_flush_out", uop_out.valid, 0);
      chk("t6_flush_full", iq_full, 0);
      step();
      chk("t6_drop_out", uop_out.valid, 0);
      chk("t6_drop_count", dut.r_count, 0);

      // Flush from full.
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < ((g == 3) ? 1 : 4); k++)
            lane(k, mk(8'h40 + 8'(4 * g + k), 6'd40, 1'b1, 6'd0, 1'b0), 1'b0, 1'b0);
         step(); clr_in();
      end
      chk("t6b_full", iq_full, 1);
      flush = 1'b1;
      step(); flush = 1'b0;
      chk("t6b_flush_full", iq_full, 0);
      chk("t6b_flush_count", dut.r_count, 0);

      // Asynchronous reset between edges.
      for (int k = 0; k < 4; k++) lane(k, mk(8'h50 + 8'(k), 6'd0, 1'b0, 6'd0, 1'b0), 1'b0, 1'b0);
      step(); clr_in();
      step();
      chk("t7_pre_issue", uop_out.rob_idx, 8'h50);
      #2 reset = 1'b1;
      #1;
      chk("t7_async_out", uop_out, 0);
      chk("t7_async_count", dut.r_count, 0);
      chk("t7_async_full", iq_full, 0);
      @(negedge clock);
      reset = 1'b0;
      step();
      chk("t7_post_idle", uop_out.valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
